// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage branch predictor: a direct-mapped BTB (valid/tag/target)
//   plus 2-bit saturating direction counters. The lookup is purely
//   combinational from registered state. Training comes from the execute stage.
//
//   Optional feature: define BP_GSHARE_EN to XOR a global history register
//   into the counter index. BTB valid/tag/target stay on the plain index.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous reset, active-high
//   bp_enable    0 forces pred_taken low (training unaffected)
//   pc           fetch PC to look up
//   pred_taken   predict taken for pc
//   pred_target  predicted next PC (BTB target on hit, else pc+4)
//   pred_hit     BTB entry valid and tag matches pc
//   upd_valid    resolved conditional branch this cycle
//   upd_pc       PC of the resolved branch
//   upd_taken    resolved direction
//   upd_target   resolved taken target
module branch_predictor #(
  parameter int unsigned ENTRIES    = 32,
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned TAG_BITS   = 8,
  parameter logic [31:0] RESET_PC   = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bp_enable,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int unsigned TAG_LSB = INDEX_BITS + 2;
  localparam int unsigned TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  logic                  valid_q [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
  logic [31:0]           tgt_q   [ENTRIES];
  logic [1:0]            ctr_q   [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, up_idx, lk_cidx, up_cidx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  up_hit;
  logic [1:0]            up_ctr, up_ctr_d;

  // Low byte-offset bits and bits above the tag take no part in training.
  logic unused_upd_bits;
  assign unused_upd_bits = ^{upd_pc[31:TAG_MSB+1], upd_pc[1:0]};

  assign lk_idx = pc[INDEX_BITS+1:2];
  assign lk_tag = pc[TAG_MSB:TAG_LSB];
  assign up_idx = upd_pc[INDEX_BITS+1:2];
  assign up_tag = upd_pc[TAG_MSB:TAG_LSB];

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;

  assign lk_cidx = lk_idx ^ ghr_q;
  assign up_cidx = up_idx ^ ghr_q;

  // History advances on every applied update, hit or miss, taken or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
    end
  end
`else
  assign lk_cidx = lk_idx;
  assign up_cidx = up_idx;
`endif

  // Lookup: zero latency, no bypass from a same-cycle update.
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = bp_enable && pred_hit && ctr_q[lk_cidx][1];
  assign pred_target = pred_hit ? tgt_q[lk_idx] : (pc + 32'd4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_cidx];

  always_comb begin
    up_ctr_d = up_ctr;
    if (upd_taken) begin
      if (up_ctr != 2'b11) up_ctr_d = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'b00) up_ctr_d = up_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= RESET_PC;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_cidx] <= up_ctr_d;
        if (upd_taken) tgt_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target;
        ctr_q[up_cidx]  <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        bp_enable;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES    (32),
    .INDEX_BITS (5),
    .TAG_BITS   (8),
    .RESET_PC   (32'h4000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bp_enable   (bp_enable),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_hit    (pred_hit),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = a;
    upd_taken  = t;
    upd_target = tgt;
    step();
    upd_valid  = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; bp_enable = 1'b1; pc = 32'h4000_0010;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    step(); step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_hit",    {31'd0, pred_hit},   32'd0);
    check("rst_taken",  {31'd0, pred_taken}, 32'd0);
    check("rst_target", pred_target,         32'h4000_0014);

    // Allocate on taken miss -> ctr 10
    upd(32'h4000_0010, 1'b1, 32'h4000_0100);
    check("alloc_hit",    {31'd0, pred_hit},   32'd1);
    check("alloc_taken",  {31'd0, pred_taken}, 32'd1);
    check("alloc_target", pred_target,         32'h4000_0100);

    // Not-taken training 10 -> 01 -> 00, target untouched
    upd(32'h4000_0010, 1'b0, 32'h4000_0DEA);
    check("nt1_taken", {31'd0, pred_taken}, 32'd0);
    upd(32'h4000_0010, 1'b0, 32'h4000_0DEA);
    check("nt2_taken",  {31'd0, pred_taken}, 32'd0);
    check("nt2_hit",    {31'd0, pred_hit},   32'd1);
    check("nt2_target", pred_target,         32'h4000_0100);
    // From 00 one taken gives 01: still not taken
    upd(32'h4000_0010, 1'b1, 32'h4000_0100);
    check("sat0_taken", {31'd0, pred_taken}, 32'd0);

    // Same index, different tag -> miss
    pc = 32'h4000_0090; #1;
    check("alias_hit",    {31'd0, pred_hit}, 32'd0);
    check("alias_target", pred_target,       32'h4000_0094);

    // Saturate at 11, then step down
    pc = 32'h4000_0020;
    repeat (4) upd(32'h4000_0020, 1'b1, 32'h4000_0200);
    check("sat3_taken", {31'd0, pred_taken}, 32'd1);
    upd(32'h4000_0020, 1'b0, 32'h4000_0000);
    check("dn1_taken",  {31'd0, pred_taken}, 32'd1);
    bp_enable = 1'b0; #1;
    check("dis_taken",  {31'd0, pred_taken}, 32'd0);
    check("dis_hit",    {31'd0, pred_hit},   32'd1);
    check("dis_target", pred_target,         32'h4000_0200);
    bp_enable = 1'b1; #1;
    upd(32'h4000_0020, 1'b0, 32'h4000_0000);
    check("dn2_taken",  {31'd0, pred_taken}, 32'd0);

    // Same-cycle lookup and allocate: no bypass
    pc = 32'h4000_0030;
    upd_valid = 1'b1; upd_pc = 32'h4000_0030; upd_taken = 1'b1; upd_target = 32'h4000_0300;
    #1;
    check("byp_hit_pre",    {31'd0, pred_hit}, 32'd0);
    check("byp_target_pre", pred_target,       32'h4000_0034);
    step();
    upd_valid = 1'b0; #1;
    check("byp_hit_post",    {31'd0, pred_hit}, 32'd1);
    check("byp_target_post", pred_target,       32'h4000_0300);

    // Reset beats a concurrent update
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h4000_0050; upd_taken = 1'b1; upd_target = 32'h4000_0500;
    step();
    rst = 1'b0; upd_valid = 1'b0; #1;
    check("rr_hit_30", {31'd0, pred_hit}, 32'd0);
    pc = 32'h4000_0010; #1;
    check("rr_hit_10", {31'd0, pred_hit}, 32'd0);
    pc = 32'h4000_0050; #1;
    check("rr_hit_50",    {31'd0, pred_hit}, 32'd0);
    check("rr_target_50", pred_target,       32'h4000_0054);
    step();
    check("rr_drop_50", {31'd0, pred_hit}, 32'd0);

    // Not-taken miss allocates nothing
    upd(32'h4000_0050, 1'b0, 32'h4000_0500);
    check("ntmiss_hit", {31'd0, pred_hit}, 32'd0);

    // pc+4 wraps
    pc = 32'hFFFF_FFFC; #1;
    check("wrap_target", pred_target, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
